regfile_cmd_port: RTL and testbench

Byte-stream command front end that drives the write and read ports of the team's register file.
- Accepts 8-bit command bytes on a valid/ready stream from the host link (UART/SPI byte layer).
- Decodes write and read commands.
- Issues single-cycle register-file writes.
- Returns read data as a byte stream.
- Sits directly upstream of the register file (write port and raddr) and directly downstream of it (rdata).

---
 rtl/regfile_cmd_port.sv | 198 +++++++++++++++++++
 tb/tb_regfile_cmd_port.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_port.sv
// Byte-stream command front end for the register file: decodes write/read
// commands, issues single-cycle writes and streams read data back MSB first.
module regfile_cmd_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              err_opcode
);

    localparam int AB   = (ADDR_W + 7) / 8;
    localparam int DB   = DATA_W / 8;
    localparam int AW8  = AB * 8;
    localparam int MAXB = (AB > DB) ? AB : DB;
    localparam int CW   = $clog2(MAXB + 1);

    localparam logic [7:0]    OP_WRITE  = 8'h01;
    localparam logic [7:0]    OP_READ   = 8'h02;
    localparam logic [CW-1:0] ADDR_LAST = CW'(AB - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_COMMIT,
        S_RLATCH,
        S_RSEND
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]     byte_cnt;
    logic              is_write;
    logic [AW8-1:0]    addr_sr;
    logic [AW8-1:0]    addr_shifted;
    logic [DATA_W-1:0] rd_sr;

    logic in_fire;
    logic out_fire;
    logic addr_done;
    logic data_done;
    logic send_done;
    logic opcode_ok;

    logic in_ready_next;
    logic out_valid_next;
    logic rf_we_next;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign opcode_ok = (in_data == OP_WRITE) || (in_data == OP_READ);
    assign addr_done = (state == S_ADDR)  && in_fire  && (byte_cnt == ADDR_LAST);
    assign data_done = (state == S_DATA)  && in_fire  && (byte_cnt == DATA_LAST);
    assign send_done = (state == S_RSEND) && out_fire && (byte_cnt == DATA_LAST);

    // Address bytes arrive MSB first; bits above ADDR_W are dropped on use.
    assign addr_shifted = AW8'({addr_sr, in_data});

    assign out_data = rd_sr[DATA_W-1 -: 8];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next before the case keeps this purely
    // combinational; a missed branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (in_fire && opcode_ok) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (addr_done) begin
                    state_next = is_write ? S_DATA : S_RLATCH;
                end
            end
            S_DATA: begin
                if (data_done) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: state_next = S_IDLE;
            S_RLATCH: state_next = S_RSEND;
            S_RSEND: begin
                if (send_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and registered, so
    // they are clean flop outputs and are low throughout reset.
    always_comb begin
        in_ready_next  = (state_next == S_IDLE) || (state_next == S_ADDR) ||
                         (state_next == S_DATA);
        out_valid_next = (state_next == S_RSEND);
        rf_we_next     = (state_next == S_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            rf_we      <= 1'b0;
            err_opcode <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_raddr   <= '0;
            addr_sr    <= '0;
            rd_sr      <= '0;
            byte_cnt   <= '0;
            is_write   <= 1'b0;
        end else begin
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
            rf_we     <= rf_we_next;

            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    if (in_fire) begin
                        is_write <= (in_data == OP_WRITE);
                        if (!opcode_ok) begin
                            err_opcode <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (in_fire) begin
                        addr_sr <= addr_shifted;
                        if (addr_done) begin
                            byte_cnt <= '0;
                            if (is_write) begin
                                rf_waddr <= addr_shifted[ADDR_W-1:0];
                            end else begin
                                rf_raddr <= addr_shifted[ADDR_W-1:0];
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (in_fire) begin
                        rf_wdata <= DATA_W'({rf_wdata, in_data});
                        if (data_done) begin
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                // rf_rdata is combinational from rf_raddr, already stable here.
                S_RLATCH: begin
                    rd_sr <= rf_rdata;
                end
                S_RSEND: begin
                    if (out_fire) begin
                        rd_sr <= rd_sr << 8;
                        if (send_done) begin
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_port.sv
// Scoreboard bench for regfile_cmd_port: a default (8/16) instance and a
// wide (10/32) instance, each backed by a small register-file model.
module tb_regfile_cmd_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [7:0]  in_data0, out_data0;
    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0]  rf_waddr0, rf_raddr0;
    logic [15:0] rf_wdata0, rf_rdata0;
    logic        rf_we0, err_opcode0;

    logic [7:0]  in_data1, out_data1;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [9:0]  rf_waddr1, rf_raddr1;
    logic [31:0] rf_wdata1, rf_rdata1;
    logic        rf_we1, err_opcode1;

    regfile_cmd_port #(.ADDR_W(8), .DATA_W(16)) dut0 (
        .clk(clk), .reset(reset),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0), .rf_we(rf_we0),
        .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0), .err_opcode(err_opcode0)
    );

    regfile_cmd_port #(.ADDR_W(10), .DATA_W(32)) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1), .rf_we(rf_we1),
        .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1), .err_opcode(err_opcode1)
    );

    // Register-file models: synchronous write, combinational read.
    logic [15:0] mem0 [0:255];
    logic [31:0] mem1 [0:1023];
    always @(posedge clk) if (rf_we0) mem0[rf_waddr0] <= rf_wdata0;
    always @(posedge clk) if (rf_we1) mem1[rf_waddr1] <= rf_wdata1;
    assign rf_rdata0 = mem0[rf_raddr0];
    assign rf_rdata1 = mem1[rf_raddr1];

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] wr_q0[$];
    logic [63:0] wr_q1[$];
    logic [7:0]  rd_q0[$];
    logic [7:0]  rd_q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // Monitors: every write pulse and every accepted out byte is popped
    // from the matching scoreboard queue and compared.
    always @(negedge clk) begin
        if (rf_we0) begin
            if (wr_q0.size() == 0) note_fail("wr0_unexpected", {32'(rf_waddr0), 32'(rf_wdata0)});
            else check("wr0", {32'(rf_waddr0), 32'(rf_wdata0)}, wr_q0.pop_front());
        end
        if (out_valid0 && out_ready0) begin
            if (rd_q0.size() == 0) note_fail("rd0_unexpected", 64'(out_data0));
            else check("rd0", 64'(out_data0), 64'(rd_q0.pop_front()));
        end
        if (rf_we1) begin
            if (wr_q1.size() == 0) note_fail("wr1_unexpected", {32'(rf_waddr1), rf_wdata1});
            else check("wr1", {32'(rf_waddr1), rf_wdata1}, wr_q1.pop_front());
        end
        if (out_valid1 && out_ready1) begin
            if (rd_q1.size() == 0) note_fail("rd1_unexpected", 64'(out_data1));
            else check("rd1", 64'(out_data1), 64'(rd_q1.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        int  n;
        logic rdy;
        n = 0;
        if (d == 0) begin in_data0 = b; in_valid0 = 1'b1; end
        else        begin in_data1 = b; in_valid1 = 1'b1; end
        rdy = (d == 0) ? in_ready0 : in_ready1;
        while (!rdy && n < 50) begin
            tick();
            n++;
            rdy = (d == 0) ? in_ready0 : in_ready1;
        end
        if (!rdy) note_fail("in_ready_timeout", 64'(b));
        else tick();
        if (d == 0) in_valid0 = 1'b0;
        else        in_valid1 = 1'b0;
    endtask

    task automatic wait_out_valid(input int d);
        int n;
        n = 0;
        while (((d == 0) ? out_valid0 : out_valid1) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) note_fail("out_valid_timeout", 64'(d));
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (((d == 0) ? out_valid0 : out_valid1) !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) note_fail("idle_timeout", 64'(d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        in_data0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 256; i++)  mem0[i] = '0;
        for (int i = 0; i < 1024; i++) mem1[i] = '0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  64'(in_ready0),   0);
        check("rst_out_valid", 64'(out_valid0),  0);
        check("rst_rf_we",     64'(rf_we0),      0);
        check("rst_err",       64'(err_opcode0), 0);
        check("rst_waddr",     64'(rf_waddr0),   0);
        check("rst_wdata",     64'(rf_wdata0),   0);
        check("rst_raddr",     64'(rf_raddr0),   0);
        check("rst_out_data",  64'(out_data0),   0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", 64'(in_ready0), 1);

        // Write 01 05 BE EF
        wr_q0.push_back({32'h05, 32'hBEEF});
        send_byte(0, 8'h01);
        send_byte(0, 8'h05);
        send_byte(0, 8'hBE);
        send_byte(0, 8'hEF);
        check("wr_we_n1",    64'(rf_we0),    1);
        check("wr_waddr",    64'(rf_waddr0), 64'h05);
        check("wr_wdata",    64'(rf_wdata0), 64'hBEEF);
        check("wr_commit_rdy", 64'(in_ready0), 0);
        tick();
        check("wr_we_n2",    64'(rf_we0),    0);
        check("wr_idle_rdy", 64'(in_ready0), 1);

        // Read 02 05 -> BE EF
        rd_q0.push_back(8'hBE);
        rd_q0.push_back(8'hEF);
        send_byte(0, 8'h02);
        send_byte(0, 8'h05);
        check("rd_valid_n1", 64'(out_valid0), 0);
        check("rd_raddr",    64'(rf_raddr0),  64'h05);
        tick();
        check("rd_valid_n2", 64'(out_valid0), 1);
        check("rd_first",    64'(out_data0),  64'hBE);
        wait_idle(0);
        check("rd_idle_rdy", 64'(in_ready0), 1);

        // Backpressure read
        out_ready0 = 1'b0;
        rd_q0.push_back(8'hBE);
        rd_q0.push_back(8'hEF);
        send_byte(0, 8'h02);
        send_byte(0, 8'h05);
        wait_out_valid(0);
        for (int i = 0; i < 5; i++) begin
            check("bp_stall_data",  64'(out_data0),  64'hBE);
            check("bp_stall_valid", 64'(out_valid0), 1);
            tick();
        end
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        check("bp_second_data", 64'(out_data0), 64'hEF);
        tick();
        check("bp_second_hold", 64'(out_data0), 64'hEF);
        check("bp_second_valid", 64'(out_valid0), 1);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        tick();
        out_ready0 = 1'b1;
        check("bp_done_valid", 64'(out_valid0), 0);
        check("bp_drained",    64'(rd_q0.size()), 0);

        // Bad opcode then write 01 03 12 34
        check("bad_err_before", 64'(err_opcode0), 0);
        send_byte(0, 8'h7F);
        check("bad_err_set",  64'(err_opcode0), 1);
        check("bad_stay_idle", 64'(in_ready0), 1);
        wr_q0.push_back({32'h03, 32'h1234});
        send_byte(0, 8'h01);
        send_byte(0, 8'h03);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        tick();
        check("bad_err_sticky", 64'(err_opcode0), 1);
        check("bad_mem3",       64'(mem0[3]),     64'h1234);

        // Reset mid-command: 01 05 BE aborted, then 01 06 CA FE
        send_byte(0, 8'h01);
        send_byte(0, 8'h05);
        send_byte(0, 8'hBE);
        reset = 1'b1;
        tick();
        check("midrst_we",    64'(rf_we0),      0);
        check("midrst_rdy",   64'(in_ready0),   0);
        check("midrst_err",   64'(err_opcode0), 0);
        check("midrst_wdata", 64'(rf_wdata0),   0);
        reset = 1'b0;
        tick();
        wr_q0.push_back({32'h06, 32'hCAFE});
        send_byte(0, 8'h01);
        send_byte(0, 8'h06);
        send_byte(0, 8'hCA);
        send_byte(0, 8'hFE);
        tick();
        check("midrst_err_after", 64'(err_opcode0), 0);
        check("midrst_mem5",      64'(mem0[5]),     64'hBEEF);
        check("midrst_mem6",      64'(mem0[6]),     64'hCAFE);

        // Wide instance: 01 FF 05 11 22 33 44, then 02 FF 05
        wr_q1.push_back({32'h305, 32'h11223344});
        send_byte(1, 8'h01);
        send_byte(1, 8'hFF);
        send_byte(1, 8'h05);
        send_byte(1, 8'h11);
        send_byte(1, 8'h22);
        send_byte(1, 8'h33);
        send_byte(1, 8'h44);
        check("w_we",    64'(rf_we1),    1);
        check("w_waddr", 64'(rf_waddr1), 64'h305);
        check("w_wdata", 64'(rf_wdata1), 64'h11223344);
        tick();
        rd_q1.push_back(8'h11);
        rd_q1.push_back(8'h22);
        rd_q1.push_back(8'h33);
        rd_q1.push_back(8'h44);
        send_byte(1, 8'h02);
        send_byte(1, 8'hFF);
        send_byte(1, 8'h05);
        check("w_raddr", 64'(rf_raddr1), 64'h305);
        tick();
        check("w_rd_valid", 64'(out_valid1), 1);
        wait_idle(1);
        check("w_idle_rdy", 64'(in_ready1), 1);

        repeat (5) tick();
        check("drain_wr0", 64'(wr_q0.size()), 0);
        check("drain_rd0", 64'(rd_q0.size()), 0);
        check("drain_wr1", 64'(wr_q1.size()), 0);
        check("drain_rd1", 64'(rd_q1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
